// File: rtl/irq_ctrl_pkg.sv
// Shared encodings for the Beta interrupt controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package irq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

    localparam logic [1:0] ADDR_MASK     = 2'd0;
    localparam logic [1:0] ADDR_MODE     = 2'd1;
    localparam logic [1:0] ADDR_PEND_CLR = 2'd2;
    localparam logic [1:0] ADDR_STATUS   = 2'd3;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set bit of req wins.
// Latency: combinational.
// Backpressure: none.
// Ports: req (NSRC request vector) -> valid (any bit set), id (index of winner).
module irq_prio_enc #(
    parameter int NSRC = 8,
    parameter int IDW  = 3
) (
    input  logic [NSRC-1:0] req,
    output logic            valid,
    output logic [IDW-1:0]  id
);

    always_comb begin
        valid = |req;
        id    = '0;
        // Scan from the top down so the lowest set index is written last.
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                id = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller for the Beta CPU: latches/masks sources, raises IRQ for the
// lowest-index eligible source, holds it until ACK, then tracks service until EOI.
// Latency: source edge at k -> pending at k+1 -> IRQ at k+2. Backpressure: IRQ held until IRQ_ACK.
// Ports: SRC in, SUPERVISOR/IRQ_ACK/EOI CPU handshakes, CFG_* register access,
//        IRQ/IRQ_ID/IN_SERVICE to the control unit.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int NSRC = 8,
    parameter int IDW  = 3
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic [NSRC-1:0] SRC,
    input  logic            SUPERVISOR,
    input  logic            IRQ_ACK,
    input  logic            EOI,
    input  logic            CFG_WE,
    input  logic [1:0]      CFG_ADDR,
    input  logic [NSRC-1:0] CFG_WDATA,
    output logic [31:0]     CFG_RDATA,
    output logic            IRQ,
    output logic [IDW-1:0]  IRQ_ID,
    output logic            IN_SERVICE
);

    state_e          state_q, state_d;
    logic [NSRC-1:0] mask_q, mask_d;
    logic [NSRC-1:0] mode_q, mode_d;
    logic [NSRC-1:0] pend_q, pend_d;
    logic [NSRC-1:0] src_prev_q, src_prev_d;
    logic [IDW-1:0]  irq_id_q, irq_id_d;

    logic [NSRC-1:0] eligible;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] clr;
    logic [NSRC-1:0] ack_vec;
    logic            win_vld;
    logic [IDW-1:0]  win_id;

    assign eligible = pend_q & mask_q;

    irq_prio_enc #(
        .NSRC (NSRC),
        .IDW  (IDW)
    ) u_prio (
        .req   (eligible),
        .valid (win_vld),
        .id    (win_id)
    );

    // Config registers and pending vector.
    always_comb begin
        mask_d     = mask_q;
        mode_d     = mode_q;
        src_prev_d = SRC;
        if (CFG_WE && (CFG_ADDR == ADDR_MASK)) mask_d = CFG_WDATA;
        if (CFG_WE && (CFG_ADDR == ADDR_MODE)) mode_d = CFG_WDATA;

        // Only a real acknowledge (while asserting) retires the serviced edge.
        ack_vec = '0;
        if ((state_q == ST_ASSERT) && IRQ_ACK) begin
            ack_vec = {{(NSRC-1){1'b0}}, 1'b1} << irq_id_q;
        end
        clr  = ack_vec | ((CFG_WE && (CFG_ADDR == ADDR_PEND_CLR)) ? CFG_WDATA : '0);
        rise = SRC & ~src_prev_q;

        // Edge bits: clear then OR in new edges, so a same-cycle set wins.
        // Level bits simply follow the registered source.
        pend_d = (mode_q & ((pend_q & ~clr) | rise)) | (~mode_q & SRC);
    end

    // Request FSM.
    always_comb begin
        state_d  = state_q;
        irq_id_d = irq_id_q;
        case (state_q)
            ST_IDLE: begin
                if (win_vld && !SUPERVISOR) begin
                    state_d  = ST_ASSERT;
                    irq_id_d = win_id;
                end
            end
            ST_ASSERT: begin
                // ACK beats a simultaneous retract.
                if (IRQ_ACK) begin
                    state_d = ST_SERVICE;
                end else if (!eligible[irq_id_q]) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (EOI) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= ST_IDLE;
            mask_q     <= '0;
            mode_q     <= '0;
            pend_q     <= '0;
            src_prev_q <= '0;
            irq_id_q   <= '0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            mode_q     <= mode_d;
            pend_q     <= pend_d;
            src_prev_q <= src_prev_d;
            irq_id_q   <= irq_id_d;
        end
    end

    assign IRQ        = (state_q == ST_ASSERT);
    assign IN_SERVICE = (state_q == ST_SERVICE);
    assign IRQ_ID     = irq_id_q;

    always_comb begin
        CFG_RDATA = '0;
        case (CFG_ADDR)
            ADDR_MASK:     CFG_RDATA = 32'(mask_q);
            ADDR_MODE:     CFG_RDATA = 32'(mode_q);
            ADDR_PEND_CLR: CFG_RDATA = 32'(pend_q);
            ADDR_STATUS:   CFG_RDATA = 32'({IN_SERVICE, IRQ, irq_id_q});
            default:       CFG_RDATA = '0;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: expected IRQ_IDs are queued when a source is driven
// and popped when IRQ rises; register reads and handshake states checked inline.
module tb_irq_ctrl;
    import irq_ctrl_pkg::*;

    localparam int NSRC = 8;
    localparam int IDW  = 3;

    logic            CLK;
    logic            RESET_N;
    logic [NSRC-1:0] SRC;
    logic            SUPERVISOR;
    logic            IRQ_ACK;
    logic            EOI;
    logic            CFG_WE;
    logic [1:0]      CFG_ADDR;
    logic [NSRC-1:0] CFG_WDATA;
    logic [31:0]     CFG_RDATA;
    logic            IRQ;
    logic [IDW-1:0]  IRQ_ID;
    logic            IN_SERVICE;

    int n_checks = 0;
    int n_err    = 0;
    logic [IDW-1:0] sb[$];

    irq_ctrl #(.NSRC(NSRC), .IDW(IDW)) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .SRC        (SRC),
        .SUPERVISOR (SUPERVISOR),
        .IRQ_ACK    (IRQ_ACK),
        .EOI        (EOI),
        .CFG_WE     (CFG_WE),
        .CFG_ADDR   (CFG_ADDR),
        .CFG_WDATA  (CFG_WDATA),
        .CFG_RDATA  (CFG_RDATA),
        .IRQ        (IRQ),
        .IRQ_ID     (IRQ_ID),
        .IN_SERVICE (IN_SERVICE)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [1:0] addr, output logic [31:0] val);
        CFG_ADDR = addr;
        #1;
        val = CFG_RDATA;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] addr, input logic [31:0] exp);
        logic [31:0] v;
        rd(addr, v);
        chk(tag, v, exp);
    endtask

    task automatic cfg_wr(input logic [1:0] addr, input logic [NSRC-1:0] data);
        CFG_WE    = 1'b1;
        CFG_ADDR  = addr;
        CFG_WDATA = data;
        step();
        CFG_WE    = 1'b0;
    endtask

    task automatic ack();
        IRQ_ACK = 1'b1;
        step();
        IRQ_ACK = 1'b0;
    endtask

    task automatic eoi();
        EOI = 1'b1;
        step();
        EOI = 1'b0;
    endtask

    // Waits for IRQ, checks the cycle count lies in [lo,hi], then pops the expected ID.
    task automatic wait_irq(input string tag, input int lo, input int hi);
        int n = 0;
        logic [IDW-1:0] exp_id;
        while (IRQ !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        n_checks++;
        assert (IRQ === 1'b1 && n >= lo && n <= hi) else begin
            n_err++;
            $error("FAIL %s_lat: observed %0d cycles irq=%b expected %0d..%0d cycles irq=1",
                   tag, n, IRQ, lo, hi);
        end
        exp_id = (sb.size() > 0) ? sb.pop_front() : '0;
        chk({tag, "_id"}, 32'(IRQ_ID), 32'(exp_id));
    endtask

    initial begin
        int n;
        RESET_N    = 1'b1;
        SRC        = '0;
        SUPERVISOR = 1'b0;
        IRQ_ACK    = 1'b0;
        EOI        = 1'b0;
        CFG_WE     = 1'b0;
        CFG_ADDR   = ADDR_MASK;
        CFG_WDATA  = '0;

        // Reset state, observed before any clock edge.
        #2 RESET_N = 1'b0;
        #1;
        chk("rst_irq", 32'(IRQ), 32'h0);
        chk("rst_insvc", 32'(IN_SERVICE), 32'h0);
        chk("rst_id", 32'(IRQ_ID), 32'h0);
        rd_chk("rst_mask", ADDR_MASK, 32'h0);
        repeat (2) step();
        RESET_N = 1'b1;
        step();

        // 1: single edge source, exact k+2 latency, ACK and EOI.
        cfg_wr(ADDR_MASK, 8'hFF);
        cfg_wr(ADDR_MODE, 8'hFF);
        rd_chk("mode_rd", ADDR_MODE, 32'h0000_00FF);
        SRC = 8'h20;
        sb.push_back(3'd5);
        step();
        SRC = '0;
        chk("t1_irq_k1", 32'(IRQ), 32'h0);
        wait_irq("t1", 1, 1);
        ack();
        chk("t1_irq_ack", 32'(IRQ), 32'h0);
        chk("t1_insvc", 32'(IN_SERVICE), 32'h1);
        rd_chk("t1_pend", ADDR_PEND_CLR, 32'h0);
        rd_chk("t1_status", ADDR_STATUS, 32'h15);
        eoi();
        chk("t1_eoi_insvc", 32'(IN_SERVICE), 32'h0);
        chk("t1_eoi_irq", 32'(IRQ), 32'h0);

        // 2: simultaneous edges, lowest index first, second re-asserts m+2 after EOI.
        SRC = 8'h44;
        sb.push_back(3'd2);
        sb.push_back(3'd6);
        step();
        SRC = '0;
        wait_irq("t2a", 1, 1);
        ack();
        rd_chk("t2_pend", ADDR_PEND_CLR, 32'h40);
        eoi();
        chk("t2_idle_gap", 32'(IRQ), 32'h0);
        wait_irq("t2b", 1, 1);
        ack();
        eoi();

        // 3: level source on bit 3.
        cfg_wr(ADDR_MODE, 8'hF7);
        rd_chk("t3_mode", ADDR_MODE, 32'h0000_00F7);
        SRC = 8'h08;
        sb.push_back(3'd3);
        wait_irq("t3a", 2, 2);
        ack();
        rd_chk("t3_pend_ack", ADDR_PEND_CLR, 32'h08);
        eoi();
        sb.push_back(3'd3);
        wait_irq("t3b", 1, 1);
        ack();
        SRC = '0;
        repeat (2) step();
        rd_chk("t3_pend_lo", ADDR_PEND_CLR, 32'h0);
        eoi();
        repeat (4) step();
        chk("t3_no_reassert", 32'(IRQ), 32'h0);
        cfg_wr(ADDR_MODE, 8'hFF);

        // 4: mask retract while asserting, then unmask.
        SRC = 8'h10;
        sb.push_back(3'd4);
        step();
        SRC = '0;
        wait_irq("t4a", 1, 1);
        cfg_wr(ADDR_MASK, 8'hEF);
        n = 0;
        while (IRQ !== 1'b0 && n < 3) begin
            step();
            n++;
        end
        chk("t4_retract", 32'(IRQ), 32'h0);
        rd_chk("t4_status", ADDR_STATUS, 32'h04);
        rd_chk("t4_pend", ADDR_PEND_CLR, 32'h10);
        cfg_wr(ADDR_MASK, 8'hFF);
        sb.push_back(3'd4);
        wait_irq("t4b", 1, 1);
        ack();
        eoi();

        // 5: supervisor blocks assertion; stray ACK/EOI ignored in IDLE.
        cfg_wr(ADDR_MASK, 8'h01);
        SUPERVISOR = 1'b1;
        SRC = 8'h01;
        step();
        SRC = '0;
        repeat (4) step();
        chk("t5_blocked", 32'(IRQ), 32'h0);
        rd_chk("t5_pend", ADDR_PEND_CLR, 32'h01);
        ack();
        rd_chk("t5_stray_ack_pend", ADDR_PEND_CLR, 32'h01);
        rd_chk("t5_stray_ack_status", ADDR_STATUS, 32'h04);
        eoi();
        rd_chk("t5_stray_eoi_status", ADDR_STATUS, 32'h04);
        SUPERVISOR = 1'b0;
        sb.push_back(3'd0);
        wait_irq("t5", 1, 2);
        ack();
        eoi();

        // 6: asynchronous reset while in service.
        cfg_wr(ADDR_MASK, 8'hFF);
        SRC = 8'h40;
        sb.push_back(3'd6);
        step();
        SRC = '0;
        wait_irq("t6", 1, 1);
        ack();
        chk("t6_insvc", 32'(IN_SERVICE), 32'h1);
        #2 RESET_N = 1'b0;
        #1;
        chk("t6_rst_irq", 32'(IRQ), 32'h0);
        chk("t6_rst_insvc", 32'(IN_SERVICE), 32'h0);
        chk("t6_rst_id", 32'(IRQ_ID), 32'h0);
        rd_chk("t6_rst_mask", ADDR_MASK, 32'h0);
        rd_chk("t6_rst_status", ADDR_STATUS, 32'h0);
        step();
        RESET_N = 1'b1;
        step();

        // 7: edge set and PEND_CLR in the same cycle: set wins; lone clear clears.
        cfg_wr(ADDR_MODE, 8'hFF);
        SRC       = 8'h02;
        CFG_WE    = 1'b1;
        CFG_ADDR  = ADDR_PEND_CLR;
        CFG_WDATA = 8'h02;
        step();
        CFG_WE = 1'b0;
        SRC    = '0;
        rd_chk("t7_set_wins", ADDR_PEND_CLR, 32'h02);
        cfg_wr(ADDR_PEND_CLR, 8'h02);
        rd_chk("t7_clr", ADDR_PEND_CLR, 32'h0);
        chk("t7_masked_irq", 32'(IRQ), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
Interrupt controller for the unpipelined Beta CPU. It collects NSRC external interrupt sources, latches and masks them, and picks the highest-priority pending one. It drives the single IRQ input of the control unit and holds it until the CPU acknowledges. It then tracks the serviced interrupt until software signals end-of-interrupt (EOI), and exposes a small register interface for mask and mode configuration.

Parameters:
NSRC, 8, number of interrupt sources (2..32)
IDW, 3, width of interrupt ID; must equal clog2(NSRC)

Ports:
CLK  in  1  system clock, all state on rising edge
RESET_N  in  1  asynchronous active-low reset
SRC  in  NSRC  interrupt sources, already synchronised to CLK
SUPERVISOR  in  1  CPU in supervisor mode (PC[31]); blocks new IRQ assertion
IRQ_ACK  in  1  one-cycle pulse: CU has taken the interrupt (PCSEL=100 committed)
EOI  in  1  one-cycle pulse: handler finished
CFG_WE  in  1  config write strobe
CFG_ADDR  in  2  0=MASK, 1=MODE (1=edge, 0=level), 2=PEND_CLR (write-1-to-clear), 3=STATUS (read-only)
CFG_WDATA  in  NSRC  config write data
CFG_RDATA  out  32  combinational read of CFG_ADDR; STATUS = {IN_SERVICE, IRQ, IRQ_ID} zero-extended; PEND_CLR reads the pending vector
IRQ  out  1  interrupt request to CU
IRQ_ID  out  IDW  ID of the asserted or in-service interrupt
IN_SERVICE  out  1  handler active, awaiting EOI

Behaviour:
- Reset (async, RESET_N=0): MASK=0, MODE=0, pending=0, SRC_prev=0, state=IDLE, IRQ=0, IRQ_ID=0, IN_SERVICE=0. Reset mid-ASSERT or mid-SERVICE aborts immediately; no ACK or EOI is required afterwards.
- Edge source i (MODE[i]=1): a rising edge (SRC[i] & ~SRC_prev[i]) sets pend[i] at the next edge. pend[i] clears on IRQ_ACK for ID i, or on a PEND_CLR write with bit i set. If a set and a clear happen in the same cycle, set wins.
- Level source i (MODE[i]=0): pend[i] = registered SRC[i]. ACK and PEND_CLR have no effect on it.
- eligible = pend & MASK. Fixed priority: lowest index wins.
- FSM, states IDLE / ASSERT / SERVICE:
  - IDLE: if eligible != 0 and SUPERVISOR=0 → ASSERT. IRQ_ID latches the winner on that edge; IRQ=1 from the next cycle.
  - ASSERT: IRQ=1, IRQ_ID frozen, no re-arbitration.
    - IRQ_ACK=1 → SERVICE: IRQ=0, IN_SERVICE=1, edge pend[IRQ_ID] cleared.
    - eligible[IRQ_ID] drops before ACK (masked or cleared) → retract: IDLE, IRQ=0. If ACK arrives in that same cycle, ACK wins.
  - SERVICE: IRQ=0, IN_SERVICE=1, IRQ_ID held. EOI=1 → IDLE with IN_SERVICE=0. No nesting.
- IRQ_ACK outside ASSERT and EOI outside SERVICE are ignored.
- SUPERVISOR is sampled only in IDLE. Once in ASSERT, it has no effect.
- Latency: source edge at cycle k → pend at k+1 → IRQ=1 at k+2. After EOI at cycle m, a still-eligible source gives IRQ=1 at m+2 (one IDLE cycle).
- Config writes take effect at the next edge. A MASK change is seen by arbitration in the cycle after the write.
- Only the low NSRC bits of CFG_WDATA are used. CFG_RDATA upper bits are 0.

Decomposition:
- Package irq_ctrl_pkg: state encoding (IDLE=2'd0, ASSERT=2'd1, SERVICE=2'd2) and CFG address constants (ADDR_MASK, ADDR_MODE, ADDR_PEND_CLR, ADDR_STATUS).
- One sub-module: irq_prio_enc, a parameterised NSRC-bit lowest-index-first priority encoder with outputs {valid, id}.

Test Plan:
- MASK=0xFF, MODE=0xFF, pulse SRC[5] one cycle at k → IRQ=1 at k+2, IRQ_ID=5. ACK → IRQ=0, IN_SERVICE=1, PEND read=0x00. EOI → IN_SERVICE=0.
- SRC[2] and SRC[6] edge in the same cycle → IRQ_ID=2. After ACK+EOI → IRQ re-asserts with IRQ_ID=6 two cycles after EOI.
- Level mode: SRC[3]=1 held, ACK, EOI, SRC[3] still 1 → IRQ re-asserts with IRQ_ID=3. SRC[3]=0 before EOI → no re-assertion.
- In ASSERT with IRQ_ID=4, write MASK=0xEF → IRQ=0 next cycle, state IDLE, pend[4] still 1. Write MASK=0xFF → IRQ=1 again with IRQ_ID=4.
- SUPERVISOR=1 with pend=0x01, MASK=0x01 → IRQ stays 0. SUPERVISOR=0 → IRQ=1 two cycles later. Stray ACK and EOI in IDLE → no state change.
- Assert RESET_N=0 in SERVICE → IRQ, IN_SERVICE, IRQ_ID, MASK and STATUS read all 0 immediately, without waiting for a clock edge.
